mean_square_acc: RTL and testbench
==================================

Name: mean_square_acc

Overview:
- Upstream feeder for the pipelined square-root block.
- Takes a stream of signed samples, squares each one and accumulates 2^LOG2_N squares per window.
- At the end of each window, emits the window mean square (sum >> LOG2_N) as a one-cycle vld_o/data_o pulse.
- The output is wired straight into the square-root stage's vld_i/data_i to form an RMS chain; that stage has no backpressure, so this block has none either.

Parameters:
- SAMPLE_WIDTH, 4, width of the signed two's-complement input sample.
- LOG2_N, 2, log2 of the window length; N = 2^LOG2_N samples per window; must be >= 1.
- DATA_WIDTH, 2*SAMPLE_WIDTH, width of the mean-square output; equals the square-root stage's DATA_WIDTH.

Ports:
- clk  input  1  clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- vld_i  input  1  sample valid; sampled every cycle; there is no ready.
- data_i  input  SAMPLE_WIDTH  signed sample.
- clr_i  input  1  synchronous window abort/restart.
- vld_o  output  1  one-cycle pulse: mean square is valid.
- data_o  output  DATA_WIDTH  unsigned mean square.
- win_idx_o  output  LOG2_N  number of samples accepted into the current window.

Behaviour:
- Reset: one synchronous, active-high reset (rst) on the single clock (clk). While rst is high, vld_o=0, data_o=0, win_idx_o=0, the accumulator is 0, the square stage is empty, and the sample counter is 0. Reset mid-window discards the partial window; no pulse is produced for it.
- Stage 1 (square register): on vld_i, register sq = data_i*data_i (signed multiply, unsigned result of DATA_WIDTH bits) together with a valid bit. Maximum value is 2^(2*SAMPLE_WIDTH-2), from the most negative input.
- Stage 2 (accumulator): width is DATA_WIDTH+LOG2_N bits and cannot overflow.
  - A valid square that is not the Nth of its window: acc <= acc + sq, count <= count + 1.
  - The Nth valid square: data_o <= (acc + sq) >> LOG2_N (truncating), vld_o <= 1 for exactly one cycle, acc <= 0, count <= 0.
  - The next window's samples accumulate with no gap cycle.
- Counting: count tracks squares accepted (stage-2 side). win_idx_o = samples accepted at the input side, modulo N.
- Latency: the Nth sample presented at cycle t gives vld_o high at cycle t+2.
- Bubbles: vld_i low stalls counting; any spacing of samples gives the same result as back-to-back samples.
- Throughput: one sample per clock, continuous.
- data_o holds its last value between pulses. vld_o is low except on the pulse cycle.
- clr_i:
  - Zeroes acc, count and win_idx_o, and invalidates the stage-1 square. The in-flight sample is discarded.
  - If vld_i is high in the same cycle as clr_i, that sample is accepted as sample 0 of the new window.
  - If clr_i coincides with a completing square in stage 2, clr_i wins: no pulse, and data_o is unchanged.
  - clr_i has no effect on a vld_o pulse already registered.
- rst has priority over clr_i, which has priority over normal operation.

Decomposition:
- Package mean_square_pkg holds:
  - the localparam functions for accumulator width (DATA_WIDTH+LOG2_N) and N;
  - a function sq_u(signed x) returning the unsigned square.
- Sub-module: signed_square_reg, the stage-1 registered squarer with its valid bit and flush input, instantiated once.

Test Plan:
- SAMPLE_WIDTH=4, LOG2_N=2: samples 1,2,3,4 back-to-back -> single vld_o pulse 2 cycles after the 4th sample, data_o=7 (30>>2).
- Samples -8,-8,-8,-8 -> data_o=64; all -1 -> data_o=1; all 0 -> data_o=0 with vld_o still pulsing.
- Eight consecutive samples of 3 then 5,5,5,5 -> pulses exactly 4 cycles apart, values 9 then 25 (no gap, acc cleared between windows); also 1,2,3,4 with random 0-3 cycle bubbles -> still 7.
- Samples 7,7, then clr_i together with sample 2, then 2,2,2 -> one pulse only, data_o=4, 2 cycles after the last sample; win_idx_o=1 the cycle after clr_i.
- rst asserted after 3 samples, then 1,1,1,1 -> outputs 0 during reset, next pulse data_o=1.
- Chain into the square-root stage with 6,6,6,6 -> root output 6, remainder 0.

Source files
------------

// File: rtl/mean_square_pkg.sv
// Shared sizing helpers and the unsigned-square function for the mean-square accumulator.
package mean_square_pkg;

  function automatic int acc_width(input int data_width, input int log2_n);
    return data_width + log2_n;
  endfunction

  function automatic int win_len(input int log2_n);
    return 1 << log2_n;
  endfunction

  // Callers sign-extend their sample to 32 bits; the square of any such value is non-negative.
  function automatic logic [63:0] sq_u(input logic signed [31:0] x);
    logic signed [63:0] xe;
    xe = 64'(x);
    return xe * xe;
  endfunction

endpackage

// File: rtl/signed_square_reg.sv
// Stage 1: registered square of a signed sample, with its valid bit.
module signed_square_reg
  import mean_square_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 4,
  parameter int DATA_WIDTH   = 2 * SAMPLE_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           vld_i,
  input  logic signed [SAMPLE_WIDTH-1:0] data_i,
  output logic                           sq_vld,
  output logic        [DATA_WIDTH-1:0]   sq
);

  // A new sample always overwrites the register, so flush only matters when no sample arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      sq_vld <= 1'b0;
      sq     <= '0;
    end else if (vld_i) begin
      sq_vld <= 1'b1;
      sq     <= DATA_WIDTH'(sq_u(32'(data_i)));
    end else begin
      sq_vld <= 1'b0;
      if (flush) sq <= '0;
    end
  end

endmodule

// File: rtl/mean_square_acc.sv
// Windowed mean-square accumulator: squares signed samples, sums 2^LOG2_N of them and
// emits sum >> LOG2_N as a one-cycle pulse. Feeds the square-root stage with no backpressure.
module mean_square_acc
  import mean_square_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 4,
  parameter int LOG2_N       = 2,
  parameter int DATA_WIDTH   = 2 * SAMPLE_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           vld_i,
  input  logic signed [SAMPLE_WIDTH-1:0] data_i,
  input  logic                           clr_i,
  output logic                           vld_o,
  output logic        [DATA_WIDTH-1:0]   data_o,
  output logic        [LOG2_N-1:0]       win_idx_o
);

  localparam int ACC_W = acc_width(DATA_WIDTH, LOG2_N);
  localparam int N     = win_len(LOG2_N);

  logic                  sq_vld;
  logic [DATA_WIDTH-1:0] sq;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      acc_sum;
  logic [LOG2_N-1:0]     count;
  logic                  last_sq;

  signed_square_reg #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_sq (
    .clk   (clk),
    .rst   (rst),
    .flush (clr_i),
    .vld_i (vld_i),
    .data_i(data_i),
    .sq_vld(sq_vld),
    .sq    (sq)
  );

  assign acc_sum = acc + ACC_W'(sq);
  assign last_sq = (count == LOG2_N'(N - 1));

  // Input-side sample index; a sample arriving with clr_i becomes sample 0 of the new window.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_idx_o <= '0;
    end else if (clr_i) begin
      win_idx_o <= LOG2_N'(vld_i);
    end else if (vld_i) begin
      win_idx_o <= win_idx_o + LOG2_N'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      count  <= '0;
      vld_o  <= 1'b0;
      data_o <= '0;
    end else begin
      vld_o <= 1'b0;
      if (clr_i) begin
        acc   <= '0;
        count <= '0;
      end else if (sq_vld) begin
        if (last_sq) begin
          data_o <= DATA_WIDTH'(acc_sum >> LOG2_N);
          vld_o  <= 1'b1;
          acc    <= '0;
          count  <= '0;
        end else begin
          acc   <= acc_sum;
          count <= count + LOG2_N'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mean_square_acc.sv
// Self-checking bench for mean_square_acc: vector table, corner-case sequences and random traffic.
module tb_mean_square_acc;

  localparam int SW  = 4;
  localparam int L2N = 2;
  localparam int DW  = 2 * SW;
  localparam int N   = 1 << L2N;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 vld_i = 1'b0;
  logic                 clr_i = 1'b0;
  logic signed [SW-1:0] data_i = '0;
  logic                 vld_o;
  logic [DW-1:0]        data_o;
  logic [L2N-1:0]       win_idx_o;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc_no = 0;
  int pulse_cnt = 0;
  int pulse_q[$];

  // Reference model: samples of the open window plus one completed mean awaiting output.
  int win_q[$];
  bit m_pend = 0;
  int m_pend_val = 0;
  bit m_vld = 0;
  int m_data = 0;

  typedef struct {
    int s[4];
    int exp;
  } vec_t;
  vec_t vecs[7];

  mean_square_acc #(
    .SAMPLE_WIDTH(SW),
    .LOG2_N      (L2N),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vld_i    (vld_i),
    .data_i   (data_i),
    .clr_i    (clr_i),
    .vld_o    (vld_o),
    .data_o   (data_o),
    .win_idx_o(win_idx_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  task automatic cyc(input bit r, input bit c, input bit v, input int d);
    rst    = r;
    clr_i  = c;
    vld_i  = v;
    data_i = SW'(d);
    @(posedge clk);
    if (r) begin
      m_vld  = 0;
      m_data = 0;
      m_pend = 0;
      win_q.delete();
    end else begin
      if (c) begin
        m_vld = 0;
      end else begin
        m_vld = m_pend;
        if (m_pend) m_data = m_pend_val;
      end
      m_pend = 0;
      if (c) win_q.delete();
      if (v) begin
        win_q.push_back(d);
        if (win_q.size() == N) begin
          int s;
          s = 0;
          foreach (win_q[i]) s += win_q[i] * win_q[i];
          m_pend     = 1;
          m_pend_val = s / N;
          win_q.delete();
        end
      end
    end
    #1;
    cyc_no++;
    check("vld_o", int'(vld_o), int'(m_vld));
    check("data_o", int'(data_o), m_data);
    check("win_idx_o", int'(win_idx_o), win_q.size());
    if (vld_o) begin
      pulse_cnt++;
      pulse_q.push_back(cyc_no);
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    int p0;
    int n;
    int d;
    bit r, c, v;

    vecs[0] = '{s: '{1, 2, 3, 4},     exp: 7};
    vecs[1] = '{s: '{-8, -8, -8, -8}, exp: 64};
    vecs[2] = '{s: '{-1, -1, -1, -1}, exp: 1};
    vecs[3] = '{s: '{0, 0, 0, 0},     exp: 0};
    vecs[4] = '{s: '{6, 6, 6, 6},     exp: 36};
    vecs[5] = '{s: '{7, -7, 7, -7},   exp: 49};
    vecs[6] = '{s: '{-8, 7, 0, 1},    exp: 28};

    repeat (2) cyc(1, 0, 0, 0);
    check("reset_vld", int'(vld_o), 0);
    check("reset_data", int'(data_o), 0);
    check("reset_idx", int'(win_idx_o), 0);

    foreach (vecs[i]) begin
      for (int j = 0; j < 4; j++) cyc(0, 0, 1, vecs[i].s[j]);
      idle();
      check("tbl_vld", int'(vld_o), 1);
      check("tbl_data", int'(data_o), vecs[i].exp);
      idle();
      check("tbl_hold", int'(data_o), vecs[i].exp);
    end

    // Three back-to-back windows: 3 x8 then 5 x4.
    p0 = pulse_cnt;
    for (int j = 0; j < 8; j++) cyc(0, 0, 1, 3);
    for (int j = 0; j < 4; j++) cyc(0, 0, 1, 5);
    idle();
    check("b2b_pulses", pulse_cnt - p0, 3);
    n = pulse_q.size();
    check("b2b_gap1", pulse_q[n-2] - pulse_q[n-3], 4);
    check("b2b_gap2", pulse_q[n-1] - pulse_q[n-2], 4);
    check("b2b_data", int'(data_o), 25);
    idle();

    // Random bubbles between samples.
    p0 = pulse_cnt;
    for (int j = 0; j < 4; j++) begin
      cyc(0, 0, 1, j + 1);
      if (j < 3) repeat ($urandom_range(0, 3)) idle();
    end
    for (int k = 0; k < 6 && pulse_cnt == p0; k++) idle();
    check("bubble_pulses", pulse_cnt - p0, 1);
    check("bubble_data", int'(data_o), 7);
    idle();

    // Clear with a coincident sample.
    p0 = pulse_cnt;
    cyc(0, 0, 1, 7);
    cyc(0, 0, 1, 7);
    cyc(0, 1, 1, 2);
    check("clr_idx", int'(win_idx_o), 1);
    for (int j = 0; j < 3; j++) cyc(0, 0, 1, 2);
    idle();
    check("clr_vld", int'(vld_o), 1);
    check("clr_data", int'(data_o), 4);
    repeat (3) idle();
    check("clr_pulses", pulse_cnt - p0, 1);

    // Reset mid-window.
    for (int j = 0; j < 3; j++) cyc(0, 0, 1, 5);
    cyc(1, 0, 1, 5);
    check("rst_data", int'(data_o), 0);
    check("rst_idx", int'(win_idx_o), 0);
    cyc(1, 0, 0, 0);
    p0 = pulse_cnt;
    for (int j = 0; j < 4; j++) cyc(0, 0, 1, 1);
    idle();
    check("rst_after_vld", int'(vld_o), 1);
    check("rst_after_data", int'(data_o), 1);
    check("rst_after_pulses", pulse_cnt - p0, 1);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 24) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = int'($urandom_range(0, 15)) - 8;
      cyc(r, c, v, d);
    end
    repeat (3) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
